// File: rtl/screen_line_fetch.sv
// ---------------------------------------------------------------------------
// screen_line_fetch
//
// Purpose:
//   Line-buffered front end for the VGA renderer's screen read port. During
//   blanking a 32-byte screen row (32x32 framebuffer starting at BASE_ADDR)
//   is pulled from CPU-shared memory through a req/grant handshake into the
//   back half of a double-buffered line buffer. The renderer then reads the
//   front half with block-RAM-like one-cycle latency, so shared memory is
//   only occupied for 32 granted cycles per row.
//
// Ports:
//   clk          system/pixel clock
//   reset        synchronous, active-low reset
//   fetch_start  pulse: fetch row fetch_row into the back bank
//   fetch_row    row index, sampled with fetch_start
//   swap         pulse: promote the back bank to front if it is valid
//   mem_req      request to the shared-memory arbiter
//   mem_grant    arbiter grant; mem_addr is consumed on req&grant cycles
//   mem_addr     shared-memory read address
//   mem_data     read data, valid one cycle after a granted address
//   fetch_busy   high from accepted fetch_start until the last byte lands
//   fetch_done   one-cycle pulse when the back bank becomes valid
//   rd_en        renderer read enable
//   rd_addr      renderer address ({row,col} + BASE_ADDR)
//   rd_data      registered read data (palette index), 0 on a miss
//   miss_count   saturating read-miss counter (optional, see below)
//
// Build option:
//   LINE_FETCH_STATS_EN - when defined, miss_count counts rd_en misses and
//   saturates at 16'hFFFF; otherwise miss_count is tied to zero.
// ---------------------------------------------------------------------------
module screen_line_fetch #(
  parameter logic [10:0] BASE_ADDR = 11'h200,
  parameter int          COLS      = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_start,
  input  logic [4:0]  fetch_row,
  input  logic        swap,
  output logic        mem_req,
  input  logic        mem_grant,
  output logic [10:0] mem_addr,
  input  logic [7:0]  mem_data,
  output logic        fetch_busy,
  output logic        fetch_done,
  input  logic        rd_en,
  input  logic [10:0] rd_addr,
  output logic [7:0]  rd_data,
  output logic [15:0] miss_count
);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t      state_q, state_d;
  logic [4:0]  col_q, col_d;
  logic        mem_req_q, mem_req_d;
  logic [10:0] mem_addr_q, mem_addr_d;
  logic        fetch_busy_q, fetch_busy_d;
  logic        fetch_done_q, fetch_done_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic [1:0]  valid_q, valid_d;
  logic [4:0]  tag_q [2];
  logic [4:0]  tag_d [2];
  logic        sel_q, sel_d;
  logic        cap_vld_q, cap_vld_d;
  logic [4:0]  cap_col_q, cap_col_d;
  logic        new_back;

  // Line buffer storage; sel_q names the front bank, ~sel_q the back bank.
  logic [7:0]  line_q [2][COLS];

  logic [10:0] rd_offset;
  logic        rd_hit;
  logic        wr_bank;

  // Offset wraps in 11 bits, so addresses below BASE_ADDR land with bit 10
  // set and are rejected along with anything past the 32x32 frame.
  assign rd_offset = rd_addr - BASE_ADDR;
  assign rd_hit    = valid_q[sel_q] && (tag_q[sel_q] == rd_offset[9:5])
                     && !rd_offset[10];
  assign wr_bank   = ~sel_q;

  // Next-state logic. The swap is resolved first so that a fetch_start in
  // the same cycle targets the bank that becomes the back after the swap.
  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    fetch_busy_d = fetch_busy_q;
    fetch_done_d = 1'b0;
    rd_data_d    = rd_data_q;
    valid_d      = valid_q;
    tag_d        = tag_q;
    sel_d        = sel_q;
    cap_vld_d    = 1'b0;
    cap_col_d    = cap_col_q;
    new_back     = ~sel_q;

    if (swap && valid_q[~sel_q]) begin
      sel_d          = ~sel_q;
      valid_d[sel_q] = 1'b0;
      new_back       = sel_q;
    end

    case (state_q)
      S_IDLE: begin
        if (fetch_start) begin
          state_d           = S_FETCH;
          tag_d[new_back]   = fetch_row;
          valid_d[new_back] = 1'b0;
          col_d             = 5'd0;
          mem_req_d         = 1'b1;
          fetch_busy_d      = 1'b1;
          mem_addr_d        = BASE_ADDR + {1'b0, fetch_row, 5'd0};
        end
      end
      S_FETCH: begin
        // A granted address returns data next cycle; remember which column
        // it belongs to so the capture stage writes the right slot.
        if (mem_grant) begin
          cap_vld_d  = 1'b1;
          cap_col_d  = col_q;
          col_d      = col_q + 5'd1;
          mem_addr_d = mem_addr_q + 11'd1;
          if (col_q == 5'd31) begin
            mem_req_d = 1'b0;
            state_d   = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // The last byte is written this cycle, so the bank is complete.
        state_d          = S_IDLE;
        valid_d[~sel_q]  = 1'b1;
        fetch_done_d     = 1'b1;
        fetch_busy_d     = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_en) begin
      rd_data_d = rd_hit ? line_q[sel_q][rd_offset[4:0]] : 8'h00;
    end
  end

  // Control and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      col_q        <= 5'd0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= 11'd0;
      fetch_busy_q <= 1'b0;
      fetch_done_q <= 1'b0;
      rd_data_q    <= 8'h00;
      valid_q      <= 2'b00;
      tag_q[0]     <= 5'd0;
      tag_q[1]     <= 5'd0;
      sel_q        <= 1'b0;
      cap_vld_q    <= 1'b0;
      cap_col_q    <= 5'd0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      fetch_busy_q <= fetch_busy_d;
      fetch_done_q <= fetch_done_d;
      rd_data_q    <= rd_data_d;
      valid_q      <= valid_d;
      tag_q        <= tag_d;
      sel_q        <= sel_d;
      cap_vld_q    <= cap_vld_d;
      cap_col_q    <= cap_col_d;
    end
  end

  // Capture stage: writes only ever go to the back bank, so the front bank
  // the renderer is reading is never disturbed.
  always_ff @(posedge clk) begin
    if (reset && cap_vld_q) begin
      line_q[wr_bank][cap_col_q] <= mem_data;
    end
  end

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_addr_q;
  assign fetch_busy = fetch_busy_q;
  assign fetch_done = fetch_done_q;
  assign rd_data    = rd_data_q;

`ifdef LINE_FETCH_STATS_EN
  logic [15:0] miss_count_q, miss_count_d;

  // Saturating count of reads that found no matching front row.
  always_comb begin
    miss_count_d = miss_count_q;
    if (rd_en && !rd_hit && (miss_count_q != 16'hFFFF)) begin
      miss_count_d = miss_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      miss_count_q <= 16'd0;
    end else begin
      miss_count_q <= miss_count_d;
    end
  end

  assign miss_count = miss_count_q;
`else
  assign miss_count = 16'h0000;
`endif

endmodule

// File: tb/tb_screen_line_fetch.sv
// ---------------------------------------------------------------------------
// tb_screen_line_fetch
//
// Directed bench for screen_line_fetch. A small shared-memory responder
// returns byte (addr[7:0] - 0x20) one cycle after each granted address, so
// row 3 reads back 0x40+col, row 6 0xA0+col and row 12 0x60+col. Every
// scenario task drives its own stimulus and compares against hand-derived
// values.
// ---------------------------------------------------------------------------
module tb_screen_line_fetch;

  logic        clk;
  logic        reset;
  logic        fetch_start;
  logic [4:0]  fetch_row;
  logic        swap;
  logic        mem_req;
  logic        mem_grant;
  logic [10:0] mem_addr;
  logic [7:0]  mem_data;
  logic        fetch_busy;
  logic        fetch_done;
  logic        rd_en;
  logic [10:0] rd_addr;
  logic [7:0]  rd_data;
  logic [15:0] miss_count;

  int errors = 0;
  int checks = 0;
  int exp_miss = 0;
  logic [10:0] addr_log [$];

  screen_line_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_start(fetch_start),
    .fetch_row  (fetch_row),
    .swap       (swap),
    .mem_req    (mem_req),
    .mem_grant  (mem_grant),
    .mem_addr   (mem_addr),
    .mem_data   (mem_data),
    .fetch_busy (fetch_busy),
    .fetch_done (fetch_done),
    .rd_en      (rd_en),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .miss_count (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_model(input logic [10:0] a);
    return a[7:0] - 8'h20;
  endfunction

  function automatic logic [15:0] exp_miss_count();
`ifdef LINE_FETCH_STATS_EN
    return 16'(exp_miss);
`else
    return 16'h0000;
`endif
  endfunction

  // Shared-memory responder: sees req&grant mid-cycle, answers just after
  // the edge that consumes the address; 0xEE marks "no valid data".
  initial begin
    logic        pend;
    logic [10:0] pa;
    mem_data = 8'hEE;
    forever begin
      @(negedge clk);
      pend = (mem_req === 1'b1) && (mem_grant === 1'b1);
      pa   = mem_addr;
      if (pend) addr_log.push_back(pa);
      @(posedge clk);
      #1;
      mem_data = pend ? mem_model(pa) : 8'hEE;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_fetch(input logic [4:0] row, input logic do_swap);
    fetch_start = 1'b1;
    fetch_row   = row;
    swap        = do_swap;
    tick();
    fetch_start = 1'b0;
    swap        = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 0;
    while (fetch_done !== 1'b1 && cyc < 200) begin
      tick();
      cyc++;
    end
  endtask

  task automatic do_read(input logic [10:0] a);
    rd_en   = 1'b1;
    rd_addr = a;
    tick();
    rd_en   = 1'b0;
  endtask

  task automatic pulse_swap();
    swap = 1'b1;
    tick();
    swap = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", mem_req); end
    checks++; if (mem_addr !== 11'h000) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 000", mem_addr); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", fetch_busy); end
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", fetch_done); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 00", rd_data); end
    checks++; if (miss_count !== 16'h0000) begin errors++; $display("[TB] FAIL reset_miss: got %h expected 0000", miss_count); end
    reset = 1'b1;
    tick();
    do_read(11'h265);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL reset_banks_invalid: got %h expected 00", rd_data); end
  endtask

  task automatic test_fetch_continuous();
    int cyc;
    int bad;
    addr_log.delete();
    mem_grant = 1'b1;
    start_fetch(5'd3, 1'b0);
    checks++; if (mem_req !== 1'b1 || fetch_busy !== 1'b1 || mem_addr !== 11'h260) begin
      errors++; $display("[TB] FAIL cont_start: got req=%b busy=%b addr=%h expected 1 1 260", mem_req, fetch_busy, mem_addr);
    end
    wait_done(cyc);
    checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL cont_latency: got %0d expected 33", cyc); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_busy_clear: got %b expected 0", fetch_busy); end
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 11'(11'h260 + i)) bad++;
    checks++; if (addr_log.size() != 32 || bad != 0) begin
      errors++; $display("[TB] FAIL cont_addr_seq: got %0d addrs %0d wrong expected 32 addrs 0 wrong", addr_log.size(), bad);
    end
    tick();
    checks++; if (fetch_done !== 1'b0) begin errors++; $display("[TB] FAIL cont_done_pulse: got %b expected 0", fetch_done); end
    pulse_swap();
    do_read(11'h265);
    checks++; if (rd_data !== 8'h45) begin errors++; $display("[TB] FAIL cont_read_265: got %h expected 45", rd_data); end
    for (int c = 0; c < 32; c++) begin
      do_read(11'(11'h260 + c));
      checks++; if (rd_data !== 8'(8'h40 + c)) begin
        errors++; $display("[TB] FAIL cont_col%0d: got %h expected %h", c, rd_data, 8'(8'h40 + c));
      end
    end
  endtask

  task automatic test_grant_toggle();
    int cyc;
    int bad;
    int hold_bad;
    logic g;
    logic [10:0] prev;
    addr_log.delete();
    start_fetch(5'd3, 1'b0);
    cyc = 0;
    hold_bad = 0;
    while (fetch_done !== 1'b1 && cyc < 200) begin
      g = (cyc % 2 == 0);
      mem_grant = g;
      prev = mem_addr;
      tick();
      cyc++;
      if (!g && mem_addr !== prev) hold_bad++;
    end
    mem_grant = 1'b1;
    checks++; if (cyc != 64) begin errors++; $display("[TB] FAIL toggle_latency: got %0d expected 64", cyc); end
    checks++; if (hold_bad != 0) begin errors++; $display("[TB] FAIL toggle_addr_hold: got %0d moves expected 0", hold_bad); end
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 11'(11'h260 + i)) bad++;
    checks++; if (addr_log.size() != 32 || bad != 0) begin
      errors++; $display("[TB] FAIL toggle_addr_seq: got %0d addrs %0d wrong expected 32 addrs 0 wrong", addr_log.size(), bad);
    end
    pulse_swap();
    bad = 0;
    for (int c = 0; c < 32; c++) begin
      do_read(11'(11'h260 + c));
      if (rd_data !== 8'(8'h40 + c)) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("[TB] FAIL toggle_contents: got %0d bad bytes expected 0", bad); end
  endtask

  task automatic test_miss();
    do_read(11'h265);
    checks++; if (rd_data !== 8'h45) begin errors++; $display("[TB] FAIL miss_pre_hit: got %h expected 45", rd_data); end
    rd_addr = 11'h285;
    tick();
    checks++; if (rd_data !== 8'h45) begin errors++; $display("[TB] FAIL miss_hold: got %h expected 45", rd_data); end
    do_read(11'h285);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL miss_row4: got %h expected 00", rd_data); end
    checks++; if (miss_count !== exp_miss_count()) begin errors++; $display("[TB] FAIL miss_count1: got %h expected %h", miss_count, exp_miss_count()); end
    do_read(11'h665);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL miss_bit10: got %h expected 00", rd_data); end
    do_read(11'h1FF);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL miss_below_base: got %h expected 00", rd_data); end
    checks++; if (miss_count !== exp_miss_count()) begin errors++; $display("[TB] FAIL miss_count3: got %h expected %h", miss_count, exp_miss_count()); end
  endtask

  task automatic test_swap_invalid_busy_start();
    int cyc;
    int bad;
    pulse_swap();
    do_read(11'h27F);
    checks++; if (rd_data !== 8'h5F) begin errors++; $display("[TB] FAIL swapinv_front_kept: got %h expected 5f", rd_data); end
    addr_log.delete();
    start_fetch(5'd6, 1'b0);
    cyc = 0;
    while (fetch_done !== 1'b1 && cyc < 200) begin
      fetch_start = (cyc == 5);
      fetch_row   = (cyc == 5) ? 5'd12 : 5'd6;
      tick();
      cyc++;
    end
    fetch_start = 1'b0;
    checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL busy_start_latency: got %0d expected 33", cyc); end
    bad = 0;
    foreach (addr_log[i]) if (addr_log[i] !== 11'(11'h2C0 + i)) bad++;
    checks++; if (addr_log.size() != 32 || bad != 0) begin
      errors++; $display("[TB] FAIL busy_start_addr_seq: got %0d addrs %0d wrong expected 32 addrs 0 wrong", addr_log.size(), bad);
    end
    pulse_swap();
    do_read(11'h2C5);
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL row6_col5: got %h expected a5", rd_data); end
    do_read(11'h2DF);
    checks++; if (rd_data !== 8'hBF) begin errors++; $display("[TB] FAIL row6_col31: got %h expected bf", rd_data); end
    do_read(11'h265);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL row3_gone: got %h expected 00", rd_data); end
    checks++; if (miss_count !== exp_miss_count()) begin errors++; $display("[TB] FAIL miss_count4: got %h expected %h", miss_count, exp_miss_count()); end
  endtask

  task automatic test_reset_mid_fetch();
    do_read(11'h2C5);
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL prereset_hit: got %h expected a5", rd_data); end
    mem_grant = 1'b1;
    start_fetch(5'd3, 1'b0);
    repeat (10) tick();
    checks++; if (mem_addr !== 11'h26A) begin errors++; $display("[TB] FAIL prereset_addr: got %h expected 26a", mem_addr); end
    reset = 1'b0;
    tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL midreset_req: got %b expected 0", mem_req); end
    checks++; if (fetch_busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b expected 0", fetch_busy); end
    checks++; if (mem_addr !== 11'h000) begin errors++; $display("[TB] FAIL midreset_addr: got %h expected 000", mem_addr); end
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL midreset_rd_data: got %h expected 00", rd_data); end
    checks++; if (miss_count !== 16'h0000) begin errors++; $display("[TB] FAIL midreset_miss: got %h expected 0000", miss_count); end
    reset = 1'b1;
    exp_miss = 0;
    repeat (3) tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("[TB] FAIL postreset_idle: got %b expected 0", mem_req); end
    do_read(11'h2C5);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL postreset_row6: got %h expected 00", rd_data); end
    pulse_swap();
    do_read(11'h265);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL postreset_row3: got %h expected 00", rd_data); end
    checks++; if (miss_count !== exp_miss_count()) begin errors++; $display("[TB] FAIL postreset_miss: got %h expected %h", miss_count, exp_miss_count()); end
  endtask

  task automatic test_swap_coincident();
    int cyc;
    mem_grant = 1'b1;
    start_fetch(5'd3, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL coin_latency: got %0d expected 33", cyc); end
    pulse_swap();
    do_read(11'h265);
    checks++; if (rd_data !== 8'h45) begin errors++; $display("[TB] FAIL swap_with_done: got %h expected 45", rd_data); end
    start_fetch(5'd12, 1'b0);
    wait_done(cyc);
    checks++; if (cyc != 33) begin errors++; $display("[TB] FAIL row12_latency: got %0d expected 33", cyc); end
    start_fetch(5'd6, 1'b1);
    do_read(11'h385);
    checks++; if (rd_data !== 8'h65) begin errors++; $display("[TB] FAIL swap_with_start_front: got %h expected 65", rd_data); end
    do_read(11'h265);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL swap_with_start_oldfront: got %h expected 00", rd_data); end
    wait_done(cyc);
    checks++; if (fetch_done !== 1'b1) begin errors++; $display("[TB] FAIL swap_with_start_done: got %b expected 1", fetch_done); end
    pulse_swap();
    do_read(11'h2C5);
    checks++; if (rd_data !== 8'hA5) begin errors++; $display("[TB] FAIL new_fetch_bank: got %h expected a5", rd_data); end
    do_read(11'h385);
    exp_miss++;
    checks++; if (rd_data !== 8'h00) begin errors++; $display("[TB] FAIL row12_now_back: got %h expected 00", rd_data); end
    checks++; if (miss_count !== exp_miss_count()) begin errors++; $display("[TB] FAIL coin_miss: got %h expected %h", miss_count, exp_miss_count()); end
  endtask

  initial begin
    reset       = 1'b0;
    fetch_start = 1'b0;
    fetch_row   = 5'd0;
    swap        = 1'b0;
    mem_grant   = 1'b0;
    rd_en       = 1'b0;
    rd_addr     = 11'h000;

    test_reset();
    test_fetch_continuous();
    test_grant_toggle();
    test_miss();
    test_swap_invalid_busy_start();
    test_reset_mid_fetch();
    test_swap_coincident();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/screen_line_fetch.md
Name: screen_line_fetch

Overview:
- Sits directly upstream of the VGA renderer's screen read port and replaces a direct connection to shared screen RAM.
- During blanking it fetches one 32-byte screen row (32x32 framebuffer at BASE_ADDR) from the CPU-shared memory through a req/grant handshake into a double-buffered line buffer.
- It then serves the renderer's reads from the line buffer with block-RAM-like 1-cycle latency.
- Result: the renderer touches shared memory for only 32 granted cycles per row.

Parameters:
- BASE_ADDR, 11'h200, byte address of screen pixel (0,0).
- COLS, 32, bytes per row (power of two; fixed at 32 in this design).

Ports:
- clk  in  1  system/pixel clock.
- reset  in  1  synchronous, active-low reset.
- fetch_start  in  1  one-cycle pulse: begin fetching row fetch_row into back bank.
- fetch_row  in  5  row index to fetch; sampled when fetch_start is high.
- swap  in  1  one-cycle pulse: promote back bank to front if back is valid.
- mem_req  out  1  request to the shared-memory arbiter.
- mem_grant  in  1  arbiter grant; mem_addr is consumed on cycles with req&grant.
- mem_addr  out  11  shared-memory read address.
- mem_data  in  8  read data, valid exactly 1 cycle after a granted address.
- fetch_busy  out  1  high from accepted fetch_start until the last byte is written.
- fetch_done  out  1  one-cycle pulse when the back bank becomes valid.
- rd_en  in  1  renderer read enable.
- rd_addr  in  11  renderer address, {row,col}+BASE_ADDR.
- rd_data  out  8  registered read data (palette index).
- miss_count  out  16  see Optional Feature.

Behaviour:
- Reset (reset==0 at a clk edge): state IDLE; mem_req=0; mem_addr=0; fetch_busy=0; fetch_done=0; rd_data=0; both banks invalid; row tags 0; bank select 0; miss_count=0. Buffer contents need not be cleared. Reset mid-fetch drops mem_req on the next edge and discards partial data.
- States:
  - IDLE: waiting for fetch_start.
  - FETCH: issuing addresses.
  - DRAIN: capturing the final byte.
- IDLE -> FETCH on fetch_start:
  - Latch fetch_row as back tag; clear back-valid.
  - Set col counter to 0; assert mem_req and fetch_busy; mem_addr = BASE_ADDR + {row,5'd0}.
- FETCH:
  - Each cycle with mem_grant=1, the address is issued and the col counter and mem_addr advance by 1.
  - A one-cycle-delayed capture pipeline (valid bit + 5-bit col) writes mem_data into back[col] on the following cycle.
  - Grant low: hold mem_addr and the counter, with no capture next cycle.
  - When col 31 is granted, drop mem_req on the next edge and go to DRAIN.
- DRAIN: capture byte 31, set back-valid, pulse fetch_done, clear fetch_busy, return to IDLE. Fetch latency with continuous grant is 33 cycles from fetch_start to fetch_done.
- fetch_start while fetch_busy: ignored; the fetch in progress completes unaffected.
- swap:
  - If back-valid: toggle bank select (front<=back, with tag), clear new back-valid.
  - Otherwise: no change, and the front keeps its old row.
  - swap and fetch_done in the same cycle: the swap sees back-valid as already set and promotes the just-completed row.
- swap in the same cycle as fetch_start: the swap is applied first, then the fetch targets the new back bank.
- Read path:
  - On rd_en, offset = rd_addr - BASE_ADDR (11-bit wrap); row = offset[9:5], col = offset[4:0].
  - Hit when front-valid, row == front tag, and offset[10]==0. Next cycle rd_data = front[col].
  - Miss: rd_data = 8'h00.
  - rd_en low: rd_data holds.
- Writes only ever target the back bank, so the front bank is never modified while being read.

Optional Feature:
- Macro LINE_FETCH_STATS_EN.
- Defined:
  - miss_count increments by 1 on each rd_en miss and saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: miss_count is tied to 16'h0000, with no counter logic.

Test Plan:
- Continuous grant, fetch_row=3, memory byte at 0x260+i = i+0x40 → mem_addr 0x260..0x27F on consecutive cycles, fetch_done at cycle 33; after swap, reading rd_addr 0x265 gives rd_data=0x45 one cycle later.
- Grant toggled 1,0,1,0 during the fetch → exactly 32 captures, no duplicated or skipped bytes, fetch_done after 64 granted/ungranted cycles, buffer contents identical to the first test.
- Read row 4 while front holds row 3 → rd_data=0x00; with LINE_FETCH_STATS_EN, miss_count increments by 1 per miss.
- swap with back invalid → front unchanged, reads of row 3 still hit; second fetch_start during busy → ignored, mem_addr sequence uninterrupted.
- reset=0 pulsed at col 10 of a fetch → mem_req=0 next cycle, fetch_busy=0, both banks invalid, subsequent reads return 0x00.
- swap coincident with fetch_done → row immediately readable next cycle; fetch_start coincident with swap → the new fetch writes the bank that was front before the swap.
